axi4_write_req_buffer: RTL and testbench
========================================

Name: axi4_write_req_buffer

Overview:
- Upstream feeder for the axi4_master simple write-request port (WRITE_ADDR/WRITE_DATA/WRITE_START/WRITE_READY/WRITE_DONE/WRITE_ERROR).
- Accepts single-word (addr, data) writes from a producer over a valid/ready stream and buffers them in a FIFO.
- Issues them to the master in groups of up to P_BURST_LEN words, then waits for the group's completion or error before issuing the next group.
- Tracks write errors for software/bench visibility.

Parameters:
- P_ADDR_WIDTH, 32, address width; must match the master.
- P_DATA_WIDTH, 32, data width; must match the master.
- P_BURST_LEN, 16, maximum words issued per group; must match the master P_BURST_LEN.
- P_FIFO_DEPTH, 32, FIFO entries; power of two, >= P_BURST_LEN.
- P_HOLDOFF_CYCLES, 64, idle-fill timeout; used only with the optional feature.

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- S_VALID  in  1  producer write request valid.
- S_READY  out  1  buffer can accept; equals not-full.
- S_ADDR  in  P_ADDR_WIDTH  producer byte address.
- S_DATA  in  P_DATA_WIDTH  producer write data.
- M_WRITE_ADDR  out  P_ADDR_WIDTH  to master WRITE_ADDR.
- M_WRITE_DATA  out  P_DATA_WIDTH  to master WRITE_DATA.
- M_WRITE_START  out  1  to master WRITE_START.
- M_WRITE_READY  in  1  from master WRITE_READY.
- M_WRITE_DONE  in  1  from master WRITE_DONE, 1-cycle pulse.
- M_WRITE_ERROR  in  1  from master WRITE_ERROR, 1-cycle pulse.
- CLEAR_ERROR  in  1  synchronous clear of ERROR_STICKY and ERROR_COUNT.
- FIFO_LEVEL  out  $clog2(P_FIFO_DEPTH)+1  current occupancy.
- BUSY  out  1  high whenever state != IDLE.
- ERROR_STICKY  out  1  set on any M_WRITE_ERROR.
- ERROR_COUNT  out  8  number of errored groups, saturating at 255.

Behaviour:
- Reset (RESET=0, async) forces the following values:
  - S_READY=0 while in reset, 1 after reset is released.
  - M_WRITE_START=0, M_WRITE_ADDR=0, M_WRITE_DATA=0.
  - FIFO empty, FIFO_LEVEL=0.
  - BUSY=0, ERROR_STICKY=0, ERROR_COUNT=0, state=IDLE.
  - Reset mid-group discards all FIFO content and the in-flight group; no completion is reported.
- FIFO push: on S_VALID & S_READY. Pop: on M_WRITE_START & M_WRITE_READY. Simultaneous push and pop when full is not possible, because S_READY=0 when full.
- FIFO_LEVEL updates the cycle after a push or pop. Push and pop in the same cycle leave the level unchanged.
- M_WRITE_ADDR and M_WRITE_DATA are the FIFO head, combinational from registered storage. They are valid whenever M_WRITE_START=1.
- State machine:
  - IDLE: go to ISSUE when FIFO_LEVEL != 0. Clear the group counter.
  - ISSUE: M_WRITE_START=1 while FIFO is non-empty. Each START&READY beat pops one word and increments the group counter.
    - Go to WAIT_RESP on the cycle the P_BURST_LEN-th word pops.
    - Also go to WAIT_RESP when the FIFO becomes empty after at least one pop; START drops in that same transition.
    - START is never asserted with an empty FIFO.
  - WAIT_RESP: M_WRITE_START=0.
    - On M_WRITE_DONE go to IDLE.
    - On M_WRITE_ERROR set ERROR_STICKY, increment ERROR_COUNT (saturating), and go to IDLE.
    - If DONE and ERROR arrive in the same cycle, treat it as an error.
- The group counter is 0..P_BURST_LEN. Latency from the first push into an empty, idle buffer to M_WRITE_START=1 is 2 cycles (push registers, then IDLE→ISSUE).
- CLEAR_ERROR has priority over a simultaneous error increment: both ERROR_STICKY and ERROR_COUNT read 0 the next cycle.
- FIFO pointers wrap modulo P_FIFO_DEPTH. Full = level==P_FIFO_DEPTH.

Optional Feature:
- Macro: WRBUF_HOLDOFF_EN.
- Defined:
  - IDLE leaves for ISSUE only when FIFO_LEVEL >= P_BURST_LEN, or when the FIFO has been non-empty for P_HOLDOFF_CYCLES consecutive cycles.
  - The holdoff counter resets on entry to IDLE and while the FIFO is empty.
- Undefined: no holdoff counter is built; IDLE leaves on any non-empty FIFO.

Test Plan:
- Single write (addr 0x00, data 0xF1) with READY=1 → START high 2 cycles after the push, for exactly one beat with ADDR=0x00, DATA=0xF1. Enters WAIT_RESP, and a DONE pulse returns it to IDLE with BUSY=0.
- Push 20 sequential words (addr 0x00..0x4C, data 0x100+i) → first group is 16 beats (0x00..0x3C). After DONE, the second group is 4 beats (0x40..0x4C). FIFO_LEVEL ends at 0.
- Fill 32 words with READY=0 → S_READY=0 at level 32 and the 33rd push is stalled. Raising READY drains the FIFO in order across the pointer wrap.
- ERROR pulse in WAIT_RESP, twice → ERROR_STICKY=1, ERROR_COUNT=2. CLEAR_ERROR together with a third error → both read 0.
- Assert RESET low during ISSUE after 5 beats → all outputs return to reset values immediately. After release, no stale START occurs and FIFO_LEVEL=0.
- With WRBUF_HOLDOFF_EN defined, push 3 words → START asserts only after 64 non-empty cycles. Pushing 16 words instead → START asserts immediately, with no holdoff wait.

Source files
------------

// File: rtl/axi4_write_req_buffer_if.sv
// Bundle of the producer stream and the axi4_master simple write-request port
// as seen by axi4_write_req_buffer.
// The master modport is the buffer's view, because the buffer issues write
// requests to the master. The slave modport is the environment's view: the
// producer and the axi4_master, or a testbench standing in for both.
interface axi4_write_req_buffer_if #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32
);
    logic                    S_VALID;
    logic                    S_READY;
    logic [P_ADDR_WIDTH-1:0] S_ADDR;
    logic [P_DATA_WIDTH-1:0] S_DATA;
    logic [P_ADDR_WIDTH-1:0] M_WRITE_ADDR;
    logic [P_DATA_WIDTH-1:0] M_WRITE_DATA;
    logic                    M_WRITE_START;
    logic                    M_WRITE_READY;
    logic                    M_WRITE_DONE;
    logic                    M_WRITE_ERROR;

    modport master (
        input  S_VALID, S_ADDR, S_DATA, M_WRITE_READY, M_WRITE_DONE, M_WRITE_ERROR,
        output S_READY, M_WRITE_ADDR, M_WRITE_DATA, M_WRITE_START
    );

    modport slave (
        output S_VALID, S_ADDR, S_DATA, M_WRITE_READY, M_WRITE_DONE, M_WRITE_ERROR,
        input  S_READY, M_WRITE_ADDR, M_WRITE_DATA, M_WRITE_START
    );
endinterface

// File: rtl/axi4_write_req_buffer.sv
// axi4_write_req_buffer: buffers single-word (addr, data) writes from a producer
// and hands them to the axi4_master write-request port in groups of up to
// P_BURST_LEN words. After each group it waits for DONE or ERROR and tracks
// errors in a sticky flag and a saturating counter.
// Optional feature macro: WRBUF_HOLDOFF_EN. When defined, IDLE holds off until a
// full group is buffered or the FIFO has stayed non-empty for P_HOLDOFF_CYCLES.
module axi4_write_req_buffer #(
    parameter int P_ADDR_WIDTH     = 32,
    parameter int P_DATA_WIDTH     = 32,
    parameter int P_BURST_LEN      = 16,
    parameter int P_FIFO_DEPTH     = 32,
    parameter int P_HOLDOFF_CYCLES = 64
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    axi4_write_req_buffer_if.master       bus,
    input  logic                          CLEAR_ERROR,
    output logic [$clog2(P_FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                          BUSY,
    output logic                          ERROR_STICKY,
    output logic [7:0]                    ERROR_COUNT
);
    localparam int PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GRP_W = $clog2(P_BURST_LEN + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

    // The pointers wrap by plain overflow, so the depth must be a power of two.
    if (P_FIFO_DEPTH < P_BURST_LEN || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0
        || P_HOLDOFF_CYCLES < 1) begin : g_bad_config
        $error("axi4_write_req_buffer: illegal parameter combination");
    end

    logic [P_ADDR_WIDTH-1:0] addr_mem [P_FIFO_DEPTH];
    logic [P_DATA_WIDTH-1:0] data_mem [P_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [1:0]              state;
    logic [GRP_W-1:0]        grp_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    issue_start;
    logic                    group_last;
    logic                    fifo_drains;
    logic                    leave_idle;

    assign fifo_full  = (FIFO_LEVEL == LVL_W'(P_FIFO_DEPTH));
    assign fifo_empty = (FIFO_LEVEL == '0);

    // Gating with RESET keeps the producer stalled for as long as reset is held.
    assign bus.S_READY = RESET && !fifo_full;
    assign push        = bus.S_VALID && bus.S_READY;

    assign issue_start       = (state == ST_ISSUE) && !fifo_empty;
    assign bus.M_WRITE_START = issue_start;
    assign pop               = issue_start && bus.M_WRITE_READY;

    // The head is forced to zero when empty so stale storage never shows after reset.
    assign bus.M_WRITE_ADDR = fifo_empty ? '0 : addr_mem[rd_ptr];
    assign bus.M_WRITE_DATA = fifo_empty ? '0 : data_mem[rd_ptr];

    assign group_last  = (grp_cnt == GRP_W'(P_BURST_LEN - 1));
    assign fifo_drains = (FIFO_LEVEL == LVL_W'(1)) && !push;
    assign BUSY        = (state != ST_IDLE);

`ifdef WRBUF_HOLDOFF_EN
    localparam int HOLD_W = $clog2(P_HOLDOFF_CYCLES + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // Count consecutive non-empty cycles spent in IDLE, saturating at the timeout.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hold_cnt <= '0;
        end else if (state != ST_IDLE || fifo_empty) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(P_HOLDOFF_CYCLES)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign leave_idle = !fifo_empty &&
                        ((FIFO_LEVEL >= LVL_W'(P_BURST_LEN)) ||
                         (hold_cnt == HOLD_W'(P_HOLDOFF_CYCLES)));
`else
    assign leave_idle = !fifo_empty;
`endif

    // Write the producer word into storage; storage itself needs no reset.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.S_ADDR;
            data_mem[wr_ptr] <= bus.S_DATA;
        end
    end

    // Advance the FIFO pointers and occupancy on push and pop.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
                default: FIFO_LEVEL <= FIFO_LEVEL;
            endcase
        end
    end

    // Group sequencing: gather beats in ISSUE, then hold in WAIT_RESP for the response.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            grp_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    grp_cnt <= '0;
                    if (leave_idle) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (pop) begin
                        grp_cnt <= grp_cnt + 1'b1;
                        if (group_last || fifo_drains) begin
                            state <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (bus.M_WRITE_ERROR || bus.M_WRITE_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Error tracking; a clear wins over an error arriving in the same cycle.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ERROR_STICKY <= 1'b0;
            ERROR_COUNT  <= '0;
        end else if (CLEAR_ERROR) begin
            ERROR_STICKY <= 1'b0;
            ERROR_COUNT  <= '0;
        end else begin
            if (bus.M_WRITE_ERROR) begin
                ERROR_STICKY <= 1'b1;
            end
            if (state == ST_WAIT_RESP && bus.M_WRITE_ERROR && ERROR_COUNT != 8'hFF) begin
                ERROR_COUNT <= ERROR_COUNT + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_write_req_buffer.sv
// Testbench for axi4_write_req_buffer (default build, WRBUF_HOLDOFF_EN undefined).
// A queue-based reference model predicts the outputs every cycle; a table of
// vectors and a few hand sequences cover the multi-cycle corner cases, followed
// by randomized traffic.
module tb_axi4_write_req_buffer;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BURST = 16;
    localparam int DEPTH = 32;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;

    logic       CLOCK;
    logic       RESET;
    logic       CLEAR_ERROR;
    logic [5:0] FIFO_LEVEL;
    logic       BUSY;
    logic       ERROR_STICKY;
    logic [7:0] ERROR_COUNT;

    axi4_write_req_buffer_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus ();

    axi4_write_req_buffer #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_BURST_LEN(BURST),
        .P_FIFO_DEPTH(DEPTH), .P_HOLDOFF_CYCLES(64)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus), .CLEAR_ERROR(CLEAR_ERROR),
        .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY), .ERROR_STICKY(ERROR_STICKY),
        .ERROR_COUNT(ERROR_COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    // Reference model: pending words in order, group phase, beats in this group.
    logic [63:0] mq[$];
    int          grp_log[$];
    int          m_phase = PH_IDLE;
    int          m_beats = 0;
    logic        m_sticky = 1'b0;
    int          m_cnt = 0;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        dn;
        logic        er;
        logic        clr;
        logic        e_start;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [5:0]  e_level;
        logic        e_busy;
        logic        e_sticky;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic vld, input logic [31:0] addr, input logic [31:0] data,
                                input logic rdy, input logic dn, input logic er, input logic clr,
                                input logic e_start, input logic [31:0] e_addr,
                                input logic [31:0] e_data, input logic [5:0] e_level,
                                input logic e_busy, input logic e_sticky, input logic [7:0] e_cnt);
        vec_t v;
        v.vld = vld; v.addr = addr; v.data = data; v.rdy = rdy; v.dn = dn; v.er = er;
        v.clr = clr; v.e_start = e_start; v.e_addr = e_addr; v.e_data = e_data;
        v.e_level = e_level; v.e_busy = e_busy; v.e_sticky = e_sticky; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase  = PH_IDLE;
        m_beats  = 0;
        m_sticky = 1'b0;
        m_cnt    = 0;
    endtask

    // Drive one cycle of inputs, compare the current outputs against the model,
    // then clock once and advance the model from the spec's rules.
    task automatic apply_stimulus(input logic vld, input logic [31:0] addr, input logic [31:0] data,
                                  input logic rdy, input logic dn, input logic er, input logic clr);
        logic        exp_ready;
        logic        exp_start;
        logic        push;
        logic        pop;
        int          sz;
        logic [63:0] head;
        bus.S_VALID       = vld;
        bus.S_ADDR        = addr;
        bus.S_DATA        = data;
        bus.M_WRITE_READY = rdy;
        bus.M_WRITE_DONE  = dn;
        bus.M_WRITE_ERROR = er;
        CLEAR_ERROR       = clr;
        sz        = mq.size();
        exp_ready = (sz < DEPTH);
        exp_start = (m_phase == PH_ISSUE) && (sz != 0);
        #1;
        check_output("s_ready", 64'(bus.S_READY), 64'(exp_ready));
        check_output("start", 64'(bus.M_WRITE_START), 64'(exp_start));
        check_output("level", 64'(FIFO_LEVEL), 64'(sz));
        check_output("busy", 64'(BUSY), 64'(m_phase != PH_IDLE));
        check_output("sticky", 64'(ERROR_STICKY), 64'(m_sticky));
        check_output("err_count", 64'(ERROR_COUNT), 64'(m_cnt));
        if (exp_start) begin
            head = mq[0];
            check_output("head_addr", 64'(bus.M_WRITE_ADDR), 64'(head[63:32]));
            check_output("head_data", 64'(bus.M_WRITE_DATA), 64'(head[31:0]));
        end
        @(posedge CLOCK);
        push = vld && exp_ready;
        pop  = exp_start && rdy;
        if (pop) begin
            void'(mq.pop_front());
            m_beats++;
        end
        if (push) mq.push_back({addr, data});
        case (m_phase)
            PH_IDLE: if (sz != 0) begin
                m_phase = PH_ISSUE;
                m_beats = 0;
            end
            PH_ISSUE: if (pop && (m_beats == BURST || mq.size() == 0)) begin
                m_phase = PH_WAIT;
                grp_log.push_back(m_beats);
            end
            default: if (er) begin
                m_sticky = 1'b1;
                if (m_cnt < 255) m_cnt++;
                m_phase = PH_IDLE;
            end else if (dn) begin
                m_phase = PH_IDLE;
            end
        endcase
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((mq.size() != 0 || m_phase != PH_IDLE) && n < limit) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, (m_phase == PH_WAIT), 1'b0, 1'b0);
            n++;
        end
        check_output(name, 64'(mq.size() == 0 && m_phase == PH_IDLE), 64'd1);
    endtask

    initial begin
        RESET = 1'b0;
        CLEAR_ERROR = 1'b0;
        bus.S_VALID = 1'b0; bus.S_ADDR = '0; bus.S_DATA = '0;
        bus.M_WRITE_READY = 1'b0; bus.M_WRITE_DONE = 1'b0; bus.M_WRITE_ERROR = 1'b0;
        model_reset();

        // Single write, then DONE+ERROR together, two errors, clear racing an error.
        vecs[0]  = mk(1, 32'h00, 32'hF1, 1, 0, 0, 0,  0, 32'h00, 32'h00, 1, 0, 0, 0);
        vecs[1]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  1, 32'h00, 32'hF1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 1, 0, 0);
        vecs[3]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 1, 0, 0);
        vecs[4]  = mk(0, 32'h00, 32'h00, 1, 1, 0, 0,  0, 32'h00, 32'h00, 0, 0, 0, 0);
        vecs[5]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 0, 0, 0);
        vecs[6]  = mk(1, 32'h10, 32'hAA, 1, 0, 0, 0,  0, 32'h00, 32'h00, 1, 0, 0, 0);
        vecs[7]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  1, 32'h10, 32'hAA, 1, 1, 0, 0);
        vecs[8]  = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 1, 0, 0);
        vecs[9]  = mk(0, 32'h00, 32'h00, 1, 1, 1, 0,  0, 32'h00, 32'h00, 0, 0, 1, 1);
        vecs[10] = mk(1, 32'h14, 32'hBB, 1, 0, 0, 0,  0, 32'h00, 32'h00, 1, 0, 1, 1);
        vecs[11] = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  1, 32'h14, 32'hBB, 1, 1, 1, 1);
        vecs[12] = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 1, 1, 1);
        vecs[13] = mk(0, 32'h00, 32'h00, 1, 0, 1, 0,  0, 32'h00, 32'h00, 0, 0, 1, 2);
        vecs[14] = mk(1, 32'h18, 32'hCC, 1, 0, 0, 0,  0, 32'h00, 32'h00, 1, 0, 1, 2);
        vecs[15] = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  1, 32'h18, 32'hCC, 1, 1, 1, 2);
        vecs[16] = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 1, 1, 2);
        vecs[17] = mk(0, 32'h00, 32'h00, 1, 0, 1, 1,  0, 32'h00, 32'h00, 0, 0, 0, 0);
        vecs[18] = mk(0, 32'h00, 32'h00, 1, 0, 0, 0,  0, 32'h00, 32'h00, 0, 0, 0, 0);

        // Values held while reset is asserted.
        repeat (3) @(posedge CLOCK);
        #1;
        check_output("rst_s_ready", 64'(bus.S_READY), 64'd0);
        check_output("rst_start", 64'(bus.M_WRITE_START), 64'd0);
        check_output("rst_addr", 64'(bus.M_WRITE_ADDR), 64'd0);
        check_output("rst_data", 64'(bus.M_WRITE_DATA), 64'd0);
        check_output("rst_level", 64'(FIFO_LEVEL), 64'd0);
        check_output("rst_busy", 64'(BUSY), 64'd0);
        check_output("rst_sticky", 64'(ERROR_STICKY), 64'd0);
        check_output("rst_count", 64'(ERROR_COUNT), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;

        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].rdy,
                           vecs[i].dn, vecs[i].er, vecs[i].clr);
            check_output($sformatf("vec%0d_start", i), 64'(bus.M_WRITE_START), 64'(vecs[i].e_start));
            check_output($sformatf("vec%0d_level", i), 64'(FIFO_LEVEL), 64'(vecs[i].e_level));
            check_output($sformatf("vec%0d_busy", i), 64'(BUSY), 64'(vecs[i].e_busy));
            check_output($sformatf("vec%0d_sticky", i), 64'(ERROR_STICKY), 64'(vecs[i].e_sticky));
            check_output($sformatf("vec%0d_count", i), 64'(ERROR_COUNT), 64'(vecs[i].e_cnt));
            if (vecs[i].e_start) begin
                check_output($sformatf("vec%0d_addr", i), 64'(bus.M_WRITE_ADDR), 64'(vecs[i].e_addr));
                check_output($sformatf("vec%0d_data", i), 64'(bus.M_WRITE_DATA), 64'(vecs[i].e_data));
            end
        end

        // Twenty sequential words split into groups of 16 and 4.
        grp_log.delete();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 32'(i * 4), 32'(32'h100 + i), 1'b1, (m_phase == PH_WAIT), 1'b0, 1'b0);
        end
        drain("seq20_drain", 100);
        check_output("seq20_groups", 64'(grp_log.size()), 64'd2);
        if (grp_log.size() == 2) begin
            check_output("seq20_group0", 64'(grp_log[0]), 64'd16);
            check_output("seq20_group1", 64'(grp_log[1]), 64'd4);
        end
        check_output("seq20_level", 64'(FIFO_LEVEL), 64'd0);

        // Fill to full with the master stalled, then drain across the pointer wrap.
        grp_log.delete();
        for (int i = 0; i < 33; i++) begin
            apply_stimulus(1'b1, 32'(32'h200 + i * 4), 32'(32'h300 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_output("full_level", 64'(FIFO_LEVEL), 64'd32);
        check_output("full_s_ready", 64'(bus.S_READY), 64'd0);
        drain("full_drain", 200);
        check_output("full_groups", 64'(grp_log.size()), 64'd2);
        if (grp_log.size() == 2) begin
            check_output("full_group0", 64'(grp_log[0]), 64'd16);
            check_output("full_group1", 64'(grp_log[1]), 64'd16);
        end

        // Reset in the middle of a group after five beats.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 32'(32'h400 + i * 4), 32'(32'h500 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 30 && !(m_phase == PH_ISSUE && m_beats == 5); n++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_output("mid_beats", 64'(m_phase == PH_ISSUE && m_beats == 5), 64'd1);
        #2;
        RESET = 1'b0;
        bus.S_VALID = 1'b0; bus.M_WRITE_READY = 1'b0;
        bus.M_WRITE_DONE = 1'b0; bus.M_WRITE_ERROR = 1'b0;
        #1;
        check_output("mid_rst_start", 64'(bus.M_WRITE_START), 64'd0);
        check_output("mid_rst_level", 64'(FIFO_LEVEL), 64'd0);
        check_output("mid_rst_busy", 64'(BUSY), 64'd0);
        check_output("mid_rst_s_ready", 64'(bus.S_READY), 64'd0);
        check_output("mid_rst_addr", 64'(bus.M_WRITE_ADDR), 64'd0);
        model_reset();
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_output("post_rst_level", 64'(FIFO_LEVEL), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                           ($urandom_range(0, 9) < 7),
                           (m_phase == PH_WAIT) && ($urandom_range(0, 2) == 0),
                           (m_phase == PH_WAIT) && ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 19) == 0));
        end
        drain("random_drain", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
